sha_message_scheduler: RTL and testbench

// - Upstream neighbour of sha_compressor. Accepts one 512-bit message block via valid/ready.
// - Streams the 64 SHA-256 schedule words W_0..W_63, one per clock.
// - Drives the 6-bit round counter that sha_compressor and Klookup consume, so the compressor's

---
 rtl/sha_message_scheduler.sv | 108 ++++++++++
 tb/tb_sha_message_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_message_scheduler.sv
// SHA-256 message scheduler: latches one 512-bit block, streams W_0..W_63 plus the round counter.
// Latency: W_0 with counter=1 the cycle after accept; W_63 with last_word 64 cycles after accept.
// Backpressure: block_ready only in IDLE or on the W_63 cycle; define SHA_SCHED_BSWAP_EN to byte-swap input words.
module sha_message_scheduler #(
    parameter logic [31:0] IDLE_W = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_valid,
    input  logic [511:0] block,
    output logic         block_ready,
    output logic [5:0]   counter,
    output logic [31:0]  W,
    output logic         running,
    output logic         last_word
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         counter_q, counter_d;
    logic [31:0]        w_q, w_d;
    logic               last_word_q, last_word_d;
    // win[0] is the word on W; win[15] is the newest word computed.
    logic [15:0][31:0]  win_q, win_d;
    logic [31:0]        new_word;
    logic               accept;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] in_word(input logic [511:0] b, input int idx);
        logic [31:0] raw;
        raw = b[511 - 32*idx -: 32];
`ifdef SHA_SCHED_BSWAP_EN
        return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
        return raw;
`endif
    endfunction

    // In RUN, counter==0 only on the k=64 (W_63) cycle, which doubles as the next accept slot.
    assign block_ready = (state_q == S_IDLE) || (counter_q == 6'd0);
    assign accept      = block_valid && block_ready;

    // Produces W_(k+15) from W_(k+13), W_(k+8), W_k, W_(k-1) while W_(k-1) is on the output.
    assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        w_d         = w_q;
        last_word_d = 1'b0;
        win_d       = win_q;
        if (accept) begin
            state_d   = S_RUN;
            counter_d = 6'd1;
            for (int i = 0; i < 16; i++) begin
                win_d[i] = in_word(block, i);
            end
            w_d = in_word(block, 0);
        end else if (state_q == S_RUN) begin
            if (counter_q == 6'd0) begin
                state_d   = S_IDLE;
                counter_d = 6'd0;
                w_d       = IDLE_W;
            end else begin
                counter_d   = counter_q + 6'd1;
                w_d         = win_q[1];
                win_d       = {new_word, win_q[15:1]};
                last_word_d = (counter_q == 6'd63);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            counter_q   <= 6'd0;
            w_q         <= IDLE_W;
            last_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            w_q         <= w_d;
            last_word_q <= last_word_d;
        end
    end

    // The window is don't-care outside RUN, so it carries no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign counter   = counter_q;
    assign W         = w_q;
    assign last_word = last_word_q;
    assign running   = (state_q == S_RUN);

endmodule

// File: tb/tb_sha_message_scheduler.sv
// Randomized scoreboard bench for sha_message_scheduler against an array-based SHA-256 schedule model.
module tb_sha_message_scheduler;

    localparam logic [31:0] IDLE_W = 32'h0;

    logic         clk = 1'b0;
    logic         reset;
    logic         block_valid;
    logic [511:0] block;
    logic         block_ready;
    logic [5:0]   counter;
    logic [31:0]  W;
    logic         running;
    logic         last_word;

    always #5 clk = ~clk;

    sha_message_scheduler #(.IDLE_W(IDLE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .block_valid (block_valid),
        .block       (block),
        .block_ready (block_ready),
        .counter     (counter),
        .W           (W),
        .running     (running),
        .last_word   (last_word)
    );

    typedef struct packed {
        logic [5:0]  c;
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           accepted = 0;
    int           dropped = 0;
    int           lw_seen = 0;
    int           patch_t[$];
    logic [31:0]  patch_v[$];
    logic [31:0]  ref_w[64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] msg_word(input logic [511:0] raw, input int i);
        logic [31:0] x;
        x = raw[511 - 32*i -: 32];
`ifdef SHA_SCHED_BSWAP_EN
        x = bswap32(x);
`endif
        return x;
    endfunction

    function automatic void build_ref(input logic [511:0] raw);
        logic [31:0] a, b;
        for (int t = 0; t < 16; t++) ref_w[t] = msg_word(raw, t);
        for (int t = 16; t < 64; t++) begin
            a = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
            b = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
            ref_w[t] = b + ref_w[t-7] + a + ref_w[t-16];
        end
    endfunction

    function automatic void push_block(input logic [511:0] raw);
        exp_t e;
        build_ref(raw);
        foreach (patch_t[i]) ref_w[patch_t[i]] = patch_v[i];
        patch_t.delete();
        patch_v.delete();
        for (int k = 1; k <= 64; k++) begin
            e.c = 6'(k % 64);
            e.w = ref_w[k-1];
            e.l = (k == 64);
            exp_q.push_back(e);
        end
        accepted++;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [511:0] abc_raw();
        logic [511:0] b;
        logic [31:0]  m;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            m = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
`ifdef SHA_SCHED_BSWAP_EN
            m = bswap32(m);
`endif
            b[511 - 32*i -: 32] = m;
        end
        return b;
    endfunction

    task automatic add_abc_patches();
        patch_t.push_back(0);  patch_v.push_back(32'h61626380);
        patch_t.push_back(15); patch_v.push_back(32'h00000018);
        patch_t.push_back(16); patch_v.push_back(32'h61626380);
        patch_t.push_back(17); patch_v.push_back(32'h000F0000);
    endtask

    task automatic step(input logic v, input logic [511:0] b, input logic r, output logic acc);
        @(negedge clk);
        block_valid = v;
        block       = b;
        reset       = r;
        acc         = 1'b0;
        if (r) begin
            if (exp_q.size() != 0) dropped++;
            exp_q.delete();
        end else if (v && block_ready) begin
            push_block(b);
            acc = 1'b1;
        end
    endtask

    task automatic send_block(input logic [511:0] b, input string name);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            step(1'b1, b, 1'b0, acc);
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_%s: block_ready never seen after %0d cycles, required accept", name, n);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, rand_block(), 1'b0, acc);
    endtask

    // Monitor: a queued entry means the DUT must be presenting that step this cycle.
    exp_t        mon_e;
    logic [40:0] got, want;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            got = {running, block_ready, counter, W, last_word};
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                want  = {1'b1, mon_e.l, mon_e.c, mon_e.w, mon_e.l};
            end else begin
                want  = {1'b0, 1'b1, 6'd0, IDLE_W, 1'b0};
            end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stream @%0t: got run=%b rdy=%b cnt=%0d W=%08h last=%b, required run=%b rdy=%b cnt=%0d W=%08h last=%b",
                         $time, got[40], got[39], got[38:33], got[32:1], got[0],
                         want[40], want[39], want[38:33], want[32:1], want[0]);
            end
            if (last_word === 1'b1) lw_seen++;
        end
    end

    initial begin
        logic         acc;
        logic [511:0] b;
        int           n;

        reset       = 1'b1;
        block_valid = 1'b1;
        block       = rand_block();
        step(1'b1, rand_block(), 1'b1, acc);
        step(1'b0, rand_block(), 1'b0, acc);
        idle(2);

        add_abc_patches();
        send_block(abc_raw(), "abc");
        idle(70);

        send_block(rand_block(), "b2b_first");
        send_block(rand_block(), "b2b_second");
        idle(70);

        send_block(rand_block(), "reset_mid");
        idle(29);
        step(1'b0, rand_block(), 1'b1, acc);
        idle(3);
        add_abc_patches();
        send_block(abc_raw(), "after_reset");
        idle(70);

        send_block(rand_block(), "stall");
        b = rand_block();
        for (int j = 1; j <= 62; j++) begin
            if (j >= 10) b = rand_block();
            step(logic'(j % 2), b, 1'b0, acc);
        end
        idle(5);

        b = rand_block();
        b[511 -: 32] = 32'h80636261;
`ifdef SHA_SCHED_BSWAP_EN
        patch_t.push_back(0); patch_v.push_back(32'h61626380);
`else
        patch_t.push_back(0); patch_v.push_back(32'h80636261);
`endif
        send_block(b, "endian");
        idle(66);

        repeat (3000) begin
            step(logic'($urandom_range(0, 9) < 7), rand_block(),
                 logic'($urandom_range(0, 199) == 0), acc);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step(1'b0, rand_block(), 1'b0, acc);
            n++;
        end
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words still pending, required 0", exp_q.size());
        end
        checks++;
        if (lw_seen != accepted - dropped) begin
            errors++;
            $display("FAIL last_word_count: got %0d pulses, required %0d", lw_seen, accepted - dropped);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
